// File: rtl/message_ctrl.sv
// Game message sequencer: hold/blink timing for level, life-lost, win and game-over screens.
// Latency: all outputs registered, one clk after the causing event; no backpressure (pulse inputs only).
module message_ctrl #(
  parameter int         HOLD_FRAMES  = 120,
  parameter int         BLINK_FRAMES = 15,
  parameter logic [1:0] FINAL_LEVEL  = 2'd3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       levelCleared,
  input  logic       playerHit,
  input  logic [1:0] livesLeft,
  input  logic       keyEnter,
  output logic [1:0] message,
  output logic       messageVisible,
  output logic       freezeGame,
  output logic [1:0] level,
  output logic       levelAdvance,
  output logic       restartGame
);

  localparam logic [7:0] HOLD_CNT   = 8'(HOLD_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {PLAY, NEXT_LEVEL, LIFE_LOST, WIN, GAME_OVER} state_t;

  state_t     state, state_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic [7:0] blink_cnt, blink_cnt_nxt;
  logic       key_prev;

  logic [1:0] message_nxt;
  logic       visible_nxt;
  logic       freeze_nxt;
  logic [1:0] level_nxt;
  logic       advance_nxt;
  logic       restart_nxt;

  logic       key_rise;
  logic       hold_done;
  logic       entering;
  logic       blink_tog;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= PLAY;
      frame_cnt      <= 8'd0;
      blink_cnt      <= 8'd0;
      key_prev       <= 1'b0;
      message        <= 2'b00;
      messageVisible <= 1'b0;
      freezeGame     <= 1'b0;
      level          <= 2'd0;
      levelAdvance   <= 1'b0;
      restartGame    <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_cnt      <= frame_cnt_nxt;
      blink_cnt      <= blink_cnt_nxt;
      key_prev       <= keyEnter;
      message        <= message_nxt;
      messageVisible <= visible_nxt;
      freezeGame     <= freeze_nxt;
      level          <= level_nxt;
      levelAdvance   <= advance_nxt;
      restartGame    <= restart_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    level_nxt   = level;
    advance_nxt = 1'b0;
    restart_nxt = 1'b0;
    key_rise    = keyEnter & ~key_prev;
    hold_done   = (frame_cnt == HOLD_CNT);

    case (state)
      PLAY: begin
        // A cleared level wins over a simultaneous hit.
        if (levelCleared)
          state_nxt = (level == FINAL_LEVEL) ? WIN : NEXT_LEVEL;
        else if (playerHit)
          state_nxt = (livesLeft <= 2'd1) ? GAME_OVER : LIFE_LOST;
      end
      NEXT_LEVEL: begin
        if (hold_done) begin
          state_nxt   = PLAY;
          level_nxt   = 2'(level + 2'd1);
          advance_nxt = 1'b1;
        end
      end
      LIFE_LOST: begin
        if (hold_done)
          state_nxt = PLAY;
      end
      WIN, GAME_OVER: begin
        // Only a fresh press after the hold restarts; a key held on entry has key_prev set.
        if (hold_done && key_rise) begin
          state_nxt   = PLAY;
          level_nxt   = 2'd0;
          restart_nxt = 1'b1;
        end
      end
      default: state_nxt = PLAY;
    endcase

    entering = (state_nxt != state);

    frame_cnt_nxt = frame_cnt;
    if (entering)
      frame_cnt_nxt = 8'd0;
    else if (startOfFrame && (frame_cnt < HOLD_CNT))
      frame_cnt_nxt = frame_cnt + 8'd1;

    blink_cnt_nxt = blink_cnt;
    blink_tog     = 1'b0;
    if (entering) begin
      blink_cnt_nxt = 8'd0;
    end else if (startOfFrame) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = 8'd0;
        blink_tog     = 1'b1;
      end else begin
        blink_cnt_nxt = blink_cnt + 8'd1;
      end
    end

    message_nxt = 2'b00;
    visible_nxt = 1'b0;
    freeze_nxt  = (state_nxt != PLAY);
    case (state_nxt)
      LIFE_LOST: begin
        message_nxt = 2'b10;
        visible_nxt = entering ? 1'b1 : (messageVisible ^ blink_tog);
      end
      WIN: begin
        message_nxt = 2'b01;
        visible_nxt = entering ? 1'b1 : (messageVisible ^ blink_tog);
      end
      GAME_OVER: begin
        message_nxt = 2'b11;
        visible_nxt = entering ? 1'b1 : (messageVisible ^ blink_tog);
      end
      default: begin
        message_nxt = 2'b00;
        visible_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_message_ctrl.sv
// Directed table-driven bench for message_ctrl plus hand-written key-restart and reset sequences.
module tb_message_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, levelCleared, playerHit, keyEnter;
  logic [1:0] livesLeft;
  logic [1:0] message;
  logic       messageVisible, freezeGame, levelAdvance, restartGame;
  logic [1:0] level;

  int n_checks = 0;
  int n_pass   = 0;
  int la_cnt   = 0;
  int rs_cnt   = 0;
  int both_cnt = 0;

  message_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .levelCleared(levelCleared), .playerHit(playerHit), .livesLeft(livesLeft),
    .keyEnter(keyEnter), .message(message), .messageVisible(messageVisible),
    .freezeGame(freezeGame), .level(level), .levelAdvance(levelAdvance),
    .restartGame(restartGame)
  );

  always #5 clk = ~clk;

  // Pulse widths measured at the falling edge: a one-cycle pulse counts once.
  always @(negedge clk) begin
    if (levelAdvance) la_cnt++;
    if (restartGame) rs_cnt++;
    if (levelAdvance && restartGame) both_cnt++;
  end

  typedef struct {
    logic       lc;
    logic       ph;
    logic [1:0] lives;
    int         nsof;
    logic [1:0] exp_msg;
    logic       exp_vis;
    logic       exp_frz;
    logic [1:0] exp_lvl;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] m, input logic v,
                          input logic f, input logic [1:0] l);
    chk({tag, ".message"}, int'(message), int'(m));
    chk({tag, ".visible"}, int'(messageVisible), int'(v));
    chk({tag, ".freeze"}, int'(freezeGame), int'(f));
    chk({tag, ".level"}, int'(level), int'(l));
  endtask

  int la0, rs0;

  initial begin
    //           lc    ph    lives nsof msg    vis   frz   lvl
    vecs[0]  = '{1'b0, 1'b0, 2'd3, 5,   2'b00, 1'b0, 1'b0, 2'd0}; // idle play
    vecs[1]  = '{1'b1, 1'b0, 2'd3, 0,   2'b00, 1'b0, 1'b1, 2'd0}; // enter NEXT_LEVEL
    vecs[2]  = '{1'b0, 1'b0, 2'd3, 119, 2'b00, 1'b0, 1'b1, 2'd0}; // still holding
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 1,   2'b00, 1'b0, 1'b0, 2'd1}; // frame 120 -> level 1
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 0,   2'b10, 1'b1, 1'b1, 2'd1}; // life lost
    vecs[5]  = '{1'b0, 1'b0, 2'd3, 14,  2'b10, 1'b1, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 2'd3, 1,   2'b10, 1'b0, 1'b1, 2'd1}; // toggle at 15
    vecs[7]  = '{1'b0, 1'b0, 2'd3, 15,  2'b10, 1'b1, 1'b1, 2'd1}; // toggle at 30
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 89,  2'b10, 1'b0, 1'b1, 2'd1}; // frame 119
    vecs[9]  = '{1'b0, 1'b0, 2'd3, 1,   2'b00, 1'b0, 1'b0, 2'd1}; // back to play, level kept
    vecs[10] = '{1'b1, 1'b0, 2'd3, 120, 2'b00, 1'b0, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 120, 2'b00, 1'b0, 1'b0, 2'd3};
    vecs[12] = '{1'b1, 1'b1, 2'd1, 0,   2'b01, 1'b1, 1'b1, 2'd3}; // clear beats hit -> WIN
    vecs[13] = '{1'b0, 1'b0, 2'd1, 120, 2'b01, 1'b1, 1'b1, 2'd3}; // WIN held, no key

    resetN = 1'b0; startOfFrame = 1'b0; levelCleared = 1'b0;
    playerHit = 1'b0; livesLeft = 2'd3; keyEnter = 1'b0;
    #23;
    chk_outs("reset", 2'b00, 1'b0, 1'b0, 2'd0);
    chk("reset.advance", int'(levelAdvance), 0);
    chk("reset.restart", int'(restartGame), 0);
    tick();
    resetN = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      levelCleared = vecs[i].lc;
      playerHit    = vecs[i].ph;
      livesLeft    = vecs[i].lives;
      tick();
      levelCleared = 1'b0;
      playerHit    = 1'b0;
      pulse_sof(vecs[i].nsof);
      tick();
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_msg, vecs[i].exp_vis,
               vecs[i].exp_frz, vecs[i].exp_lvl);
      if (i == 3)  chk("advance_after_l1", la_cnt, 1);
      if (i == 9)  chk("advance_after_lifelost", la_cnt, 1);
      if (i == 11) chk("advance_after_l3", la_cnt, 3);
    end

    // WIN exit on a fresh key press after the hold.
    rs0 = rs_cnt;
    keyEnter = 1'b1;
    tick(); tick();
    keyEnter = 1'b0;
    tick();
    chk_outs("win_exit", 2'b00, 1'b0, 1'b0, 2'd0);
    chk("win_restart", rs_cnt - rs0, 1);

    // GAME_OVER: early press ignored, later press restarts.
    playerHit = 1'b1; livesLeft = 2'd1;
    tick();
    playerHit = 1'b0;
    chk("go_enter.message", int'(message), 3);
    pulse_sof(50);
    keyEnter = 1'b1;
    tick(); tick();
    keyEnter = 1'b0;
    tick();
    chk("go_early_key.message", int'(message), 3);
    pulse_sof(70);
    tick();
    rs0 = rs_cnt;
    keyEnter = 1'b1;
    tick(); tick();
    keyEnter = 1'b0;
    tick();
    chk_outs("go_exit", 2'b00, 1'b0, 1'b0, 2'd0);
    chk("go_restart", rs_cnt - rs0, 1);

    // Key held through entry must not restart until released and pressed again.
    keyEnter = 1'b1;
    tick();
    playerHit = 1'b1; livesLeft = 2'd0;
    tick();
    playerHit = 1'b0;
    pulse_sof(125);
    tick(); tick();
    chk("held_key.message", int'(message), 3);
    keyEnter = 1'b0;
    tick(); tick();
    chk("released_key.message", int'(message), 3);
    rs0 = rs_cnt;
    keyEnter = 1'b1;
    tick(); tick();
    keyEnter = 1'b0;
    tick();
    chk("repress.message", int'(message), 0);
    chk("repress_restart", rs_cnt - rs0, 1);

    // Reset in the middle of a LIFE_LOST hold, from level 1.
    levelCleared = 1'b1;
    tick();
    levelCleared = 1'b0;
    pulse_sof(120);
    tick(); tick();
    chk("pre_reset.level", int'(level), 1);
    playerHit = 1'b1; livesLeft = 2'd2;
    tick();
    playerHit = 1'b0;
    pulse_sof(60);
    chk("pre_reset.message", int'(message), 2);
    #2;
    resetN = 1'b0;
    #1;
    chk_outs("midreset", 2'b00, 1'b0, 1'b0, 2'd0);
    chk("midreset.advance", int'(levelAdvance), 0);
    chk("midreset.restart", int'(restartGame), 0);
    la0 = la_cnt;
    rs0 = rs_cnt;
    tick(); tick();
    resetN = 1'b1;
    pulse_sof(130);
    tick(); tick();
    chk_outs("post_reset", 2'b00, 1'b0, 1'b0, 2'd0);
    chk("post_reset.no_advance", la_cnt - la0, 0);
    chk("post_reset.no_restart", rs_cnt - rs0, 0);
    chk("never_both_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
